// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the word/address widths, the opcode constants, the FSM state
// encoding, the Done watchdog limit and a helper that extracts the opcode
// field of an instruction word.
package unidade_busca_pkg;

    localparam int WORD_W = 9;
    localparam int ADDR_W = 5;
    localparam int WDOG_W = 4;

    localparam logic [WDOG_W-1:0] WDOG_MAX = 4'd15;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LATCH     = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_LATCH_IMM = 3'd4,
        S_EXEC      = 3'd5,
        S_NEXT      = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    // Instruction layout: opcode [8:6], Rx [5:3], Ry [2:0].
    function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[8:6];
    endfunction

endpackage

// File: rtl/unidade_busca_pc.sv
// contador_programa: 5-bit program counter.
// Ports:
//   clk   - system clock (rising edge)
//   rst_n - asynchronous active-low reset, forces pc to 0
//   clr   - synchronous load of zero (has priority over inc)
//   inc   - synchronous increment, wraps 31 -> 0 without any flag
//   pc    - current program counter value
module contador_programa
    import unidade_busca_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit for a small 9-bit processor.
// Fetches one- or two-word instructions from a synchronous-read memory,
// presents them to the control unit and waits for Done, with a watchdog
// that halts the unit if Done never arrives.
// Ports:
//   Clock     - system clock (rising edge)
//   Resetn    - asynchronous active-low reset
//   Start     - starts execution at address 0 from IDLE or HALT
//   MemAddr   - instruction memory word address (equals the PC)
//   MemData   - memory read word, valid the cycle after MemAddr is sampled
//   Done      - instruction-complete flag from the control unit
//   Instrucao - registered instruction word
//   DIN       - registered immediate for mvi, zero otherwise
//   Run       - instruction present and executing
//   Halted    - unit is in HALT
//   Erro      - sticky watchdog-expiry flag, cleared by the next Start
module unidade_busca
    import unidade_busca_pkg::*;
(
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [WORD_W-1:0] MemData,
    input  logic              Done,
    output logic [WORD_W-1:0] Instrucao,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic              Halted,
    output logic              Erro
);

    state_t            state;
    logic [WDOG_W-1:0] wdog;
    logic              pc_clr;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;

    // The PC moves on the same edge as the FSM transition that needs it:
    // cleared when leaving IDLE/HALT, bumped whenever a word is latched.
    always_comb begin
        pc_clr = 1'b0;
        pc_inc = 1'b0;
        case (state)
            S_IDLE, S_HALT:       pc_clr = Start;
            S_LATCH, S_LATCH_IMM: pc_inc = 1'b1;
            default:              ;
        endcase
    end

    contador_programa u_pc (
        .clk   (Clock),
        .rst_n (Resetn),
        .clr   (pc_clr),
        .inc   (pc_inc),
        .pc    (pc)
    );

    assign MemAddr = pc;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            Instrucao <= '0;
            DIN       <= '0;
            Run       <= 1'b0;
            Halted    <= 1'b0;
            Erro      <= 1'b0;
            wdog      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state <= S_FETCH;
                    end
                end

                // Memory samples MemAddr at the end of this cycle.
                S_FETCH: begin
                    state <= S_LATCH;
                end

                S_LATCH: begin
                    Instrucao <= MemData;
                    DIN       <= '0;
                    case (opcode_of(MemData))
                        OP_MVI: begin
                            state <= S_FETCH_IMM;
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            Halted <= 1'b1;
                        end
                        default: begin
                            state <= S_EXEC;
                            Run   <= 1'b1;
                            wdog  <= '0;
                        end
                    endcase
                end

                S_FETCH_IMM: begin
                    state <= S_LATCH_IMM;
                end

                S_LATCH_IMM: begin
                    DIN   <= MemData;
                    state <= S_EXEC;
                    Run   <= 1'b1;
                    wdog  <= '0;
                end

                // Done takes priority over a watchdog expiry in the same cycle.
                S_EXEC: begin
                    if (Done) begin
                        state <= S_NEXT;
                        Run   <= 1'b0;
                    end else if (wdog == WDOG_MAX - 4'd1) begin
                        wdog   <= WDOG_MAX;
                        Erro   <= 1'b1;
                        Run    <= 1'b0;
                        Halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        wdog <= wdog + 4'd1;
                    end
                end

                // One Run=0 cycle so the control unit can clear its step counter.
                S_NEXT: begin
                    DIN   <= '0;
                    state <= S_FETCH;
                end

                S_HALT: begin
                    if (Start) begin
                        state  <= S_FETCH;
                        Halted <= 1'b0;
                        Erro   <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001: Clock  input  1  single system clock; all state changes on its rising edge.
REQ-002: Resetn  input  1  asynchronous, active-low reset.
REQ-003: Start  input  1  level; when high in IDLE or HALT, begins execution at address 0.
REQ-004: MemAddr  output  5  word address to the instruction memory; always equals the PC register.
REQ-005: MemData  input  9  memory read word, valid the cycle after MemAddr is sampled by the memory (1-cycle synchronous read).
REQ-006: Done  input  1  instruction-complete flag from the control unit.
REQ-007: Instrucao  output  9  registered instruction word (opcode [8:6], Rx [5:3], Ry [2:0]).
REQ-008: DIN  output  9  registered immediate word for mvi; zero for all other opcodes.
REQ-009: Run  output  1  level; instruction present and executing.
REQ-010: Halted  output  1  high in HALT state.
REQ-011: Erro  output  1  sticky; set on Done watchdog expiry.

Function
REQ-012: The FSM SHALL have the states IDLE, FETCH, LATCH, FETCH_IMM, LATCH_IMM, EXEC, NEXT and HALT.
- IDLE: Start=1 -> PC=0, go to FETCH.
- FETCH: one cycle; MemAddr=PC -> LATCH.
- LATCH: Instrucao<=MemData, PC<=PC+1; opcode 001 -> FETCH_IMM; opcode 111 -> HALT; else -> EXEC.
- FETCH_IMM: one cycle -> LATCH_IMM.
- LATCH_IMM: DIN<=MemData, PC<=PC+1 -> EXEC.
- EXEC: Run=1 until Done is sampled high -> NEXT.
- NEXT: one cycle with Run=0 (lets the control unit clear Tstep); DIN<=0 -> FETCH.
- HALT: Halted=1; Start=1 -> PC=0, Erro cleared, go to FETCH.
REQ-013: Single-word instruction latency SHALL be 2 cycles from entering FETCH to Run=1; an mvi SHALL take 4 cycles.
REQ-014: Run SHALL deassert in the cycle after Done is sampled high; Done outside EXEC SHALL be ignored.
REQ-015: The PC SHALL be 5 bits and wrap from 31 to 0 with no flag; the immediate fetch also wraps.
REQ-016: Opcode 111 SHALL NOT assert Run; the PC after a halt points past the halt word.
REQ-017: Watchdog: a 4-bit counter SHALL clear on EXEC entry and increment each EXEC cycle with Done=0.
- On reaching 15: Erro<=1, Run drops, state goes to HALT.
- Done and expiry in the same cycle: Done wins and Erro stays 0.
REQ-018: Start high in any state other than IDLE or HALT SHALL be ignored.
REQ-019: Instrucao and DIN SHALL be stable for the whole of EXEC.

Reset
REQ-020: Resetn=0 SHALL immediately, regardless of the clock, force the following values, including mid-fetch or mid-EXEC:
- state=IDLE, PC=0;
- Instrucao=0, DIN=0;
- Run=0, Halted=0, Erro=0;
- watchdog=0.
REQ-021: After Resetn rises, the block SHALL remain in IDLE until Start is sampled high.

Structure
REQ-022: A shared package SHALL hold WORD_W=9, ADDR_W=5, the opcode constants (MV=000, MVI=001, ADD=010, SUB=011, HALT=111), the state encoding and WDOG_MAX=15.
REQ-023: The PC SHALL be a sub-module contador_programa with load-zero and increment enables, 5-bit wrap and async active-low reset; everything else SHALL be inline in unidade_busca.

Verification
REQ-024: Memory {000_001_010, 111_000_000}, Start pulse, Done returned 1 cycle after Run -> Instrucao=0x00A, Run high 2 cycles after FETCH entry, then Halted=1 with PC=2.
REQ-025: Memory {001_011_000, 0x155, 111_...} -> Instrucao=0x058 and DIN=0x155 while Run=1, reached 4 cycles after FETCH; DIN=0 after NEXT.
REQ-026: Done never asserted -> after 15 EXEC cycles: Erro=1, Run=0, Halted=1; a following Start clears Erro and fetches address 0.
REQ-027: PC preloaded to 31 via a 31-instruction run with an mvi at 31 -> immediate read from address 0 and PC=1 afterwards.
REQ-028: Resetn pulsed low mid-EXEC and mid-LATCH_IMM -> all outputs 0 within the same cycle; with Start=0 the block stays in IDLE.
REQ-029: Done held high continuously -> each instruction still gets exactly one NEXT cycle with Run=0 between consecutive EXEC phases.
